mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, synchronous-read memory between the multicycle core and a host/debug port.
//  The host port is used by the program loader and for result readback.
//  Sits between the core mem_* interface and the memory macro.
//  Gates core progress through a clock-enable (c_en) and holds core read data across stalls.
//  Supports host-requested core halt and bounds how long the host may block the core.
// PARAMETERS
//  WADDR       32  address width
//  WDATA       32  data width
//  HOST_BURST  4   max consecutive host grants while core is requesting (>=1)
//  BOOT_ADDR   0   address read during rst (supplies core reset vector)
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous, active-high reset
//  c_read     in   1      core read request
//  c_wren     in   1      core write request
//  c_addr     in   WADDR  core address
//  c_size     in   2      core access size (mem_addr_t)
//  c_wdata    in   WDATA  core write data
//  c_rdata    out  WDATA  core read data (live or held)
//  c_en       out  1      core may advance state this cycle
//  h_req      in   1      host request (read or write)
//  h_wren     in   1      host write (valid with h_req)
//  h_addr     in   WADDR  host address
//  h_size     in   2      host access size
//  h_wdata    in   WDATA  host write data
//  h_gnt      out  1      host request accepted this cycle
//  h_rvalid   out  1      host read data valid (one cycle after granted read)
//  h_rdata    out  WDATA  host read data
//  halt_req   in   1      host requests the core be parked
//  halted     out  1      core parked, no core access outstanding
//  m_read     out  1      memory read enable
//  m_wren     out  1      memory write enable
//  m_addr     out  WADDR  memory address
//  m_size     out  2      memory access size
//  m_wdata    out  WDATA  memory write data
//  m_rdata    in   WDATA  memory read data (valid cycle after m_read)
// BEHAVIOUR
//  - core_req = c_read | c_wren; at most one memory access per cycle.
//  - rst: m_read=1, m_addr=BOOT_ADDR, m_wren=0, c_en=0, h_gnt=0, h_rvalid=0, halted=0.
//    Reset values: run_cnt=0, hold=0, r_owner<=CORE.
//    Core sees m_rdata on c_rdata; rst held >=2 cycles delivers the boot word.
//  - Priority, evaluated each cycle, first match wins:
//    1) halt_req: core not granted, c_en=0; host granted iff h_req.
//    2) h_req & (!core_req | run_cnt<HOST_BURST): host granted; c_en = !core_req.
//    3) otherwise: core granted iff core_req; c_en=1; h_gnt=0.
//  - run_cnt: +1 on host grant while core_req (saturates at HOST_BURST).
//    Cleared on core grant or when !core_req.
//  - Memory mux: the granted requester drives m_*; no grant -> m_read=0, m_wren=0.
//  - Read return: r_owner (NONE/CORE/HOST) is registered from the granted read (not write).
//    - h_rvalid = (r_owner==HOST); h_rdata = m_rdata.
//    - c_rdata = (r_owner==CORE) ? m_rdata : hold.
//    - hold <= m_rdata when r_owner==CORE.
//    - So the core keeps its last read word while stalled.
//  - halted = registered (halt_req & r_owner!=CORE).
//    Deasserts the cycle after halt_req falls; core resumes at the same request.
//  - Stalled core must re-present an identical request; the arbiter does not latch core requests.
//  - Host with h_req held gets a grant within HOST_BURST+1 cycles unless halt_req=0 and core requests forever.
//    In that case the host is bounded by alternation: after a core grant, run_cnt=0 and the host wins next.
//  - rst mid-transfer: outstanding return dropped (h_rvalid=0 next cycle); no write issued during rst.
// STRUCTURE
//  - Shared package: mem_addr_t (existing), new owner_t {OWN_NONE, OWN_CORE, OWN_HOST}.
//  - Single module, no sub-module.
//  - Regs: run_cnt ($clog2(HOST_BURST+1) bits), r_owner, hold, halted.
// TESTING
//  - Boot: rst 2 cycles, mem[0]=0x80 -> c_rdata=0x80 in 2nd rst cycle; c_en=0 throughout rst.
//  - Core only: core reads 0x100 (mem=0xDEADBEEF) -> m_read=1, c_en=1; next cycle c_rdata=0xDEADBEEF.
//  - Contention, HOST_BURST=4: host+core request continuously.
//    -> host granted 4 cycles (c_en=0), core 1 cycle, repeat.
//  - Hold: core read of 0x200 (=0x1234) granted, then host wins 3 cycles.
//    -> c_rdata stays 0x1234 while c_en=0.
//  - Halt: halt_req=1 with core reading -> halted=1 cycle after last core return.
//    Host writes 0x40=0x5 then reads -> h_rvalid with 0x5.
//    Drop halt_req -> c_en resumes next cycle.
//  - Reset mid-read: host read granted, rst next cycle -> h_rvalid=0, run_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types for the memory port arbiter.
//   mem_addr_t : access size carried alongside every memory address.
//   owner_t    : which requester the memory read data returning this cycle
//                belongs to.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_addr_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

   // Saturating increment used by the host burst counter.
   function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max);
      return (val >= max) ? max : val + 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, synchronous-read memory between the multicycle
//   core and a host/debug port (program loader, result readback).
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     c_read/c_wren/c_addr/c_size/c_wdata
//                                   core request (not latched here)
//     c_rdata                       core read data, live or held across stalls
//     c_en                          core may advance its state this cycle
//     h_req/h_wren/h_addr/h_size/h_wdata
//                                   host request
//     h_gnt                         host request accepted this cycle
//     h_rvalid/h_rdata              host read data, cycle after a granted read
//     halt_req/halted               host-requested core park / park status
//     m_read/m_wren/m_addr/m_size/m_wdata/m_rdata
//                                   memory macro port (read data one cycle
//                                   after m_read)
//
//   Handshake: a requester presents its request and holds it with stable
//   fields every cycle until accepted. The host is accepted when h_gnt=1; the
//   core is accepted when it requests and c_en=1. Nothing is latched, so a
//   stalled requester re-presents the identical request the next cycle.
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int               WADDR      = 32,
   parameter int               WDATA      = 32,
   parameter int               HOST_BURST = 4,
   parameter logic [WADDR-1:0] BOOT_ADDR  = '0
) (
   input  logic             clk,
   input  logic             rst,
   // core side
   input  logic             c_read,
   input  logic             c_wren,
   input  logic [WADDR-1:0] c_addr,
   input  mem_addr_t        c_size,
   input  logic [WDATA-1:0] c_wdata,
   output logic [WDATA-1:0] c_rdata,
   output logic             c_en,
   // host side
   input  logic             h_req,
   input  logic             h_wren,
   input  logic [WADDR-1:0] h_addr,
   input  mem_addr_t        h_size,
   input  logic [WDATA-1:0] h_wdata,
   output logic             h_gnt,
   output logic             h_rvalid,
   output logic [WDATA-1:0] h_rdata,
   input  logic             halt_req,
   output logic             halted,
   // memory side
   output logic             m_read,
   output logic             m_wren,
   output logic [WADDR-1:0] m_addr,
   output mem_addr_t        m_size,
   output logic [WDATA-1:0] m_wdata,
   input  logic [WDATA-1:0] m_rdata
);

   localparam int               RUN_W     = $clog2(HOST_BURST + 1);
   localparam logic [RUN_W-1:0] BURST_MAX = RUN_W'(HOST_BURST);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [RUN_W-1:0] r_run_cnt;
   owner_t           r_owner;
   logic [WDATA-1:0] r_hold;
   logic             r_halted;

   logic             w_core_req;
   logic             w_core_gnt;
   logic             w_host_gnt;
   logic             w_core_is_read;
   logic [RUN_W-1:0] w_run_nxt;
   owner_t           w_owner_nxt;

   assign w_core_req = c_read | c_wren;
   // A core request with both strobes set is treated as a write, so it never
   // produces a read return.
   assign w_core_is_read = c_read & ~c_wren;

   // ---------------------------------------------------------------------------
   // Grant decision: halt, then host (within its burst budget), then core.
   // ---------------------------------------------------------------------------
   always_comb begin
      w_core_gnt = 1'b0;
      w_host_gnt = 1'b0;
      c_en       = 1'b0;
      if (rst) begin
         // boot read owns the memory; nobody is granted
      end else if (halt_req) begin
         w_host_gnt = h_req;
      end else if (h_req && (!w_core_req || (r_run_cnt < BURST_MAX))) begin
         w_host_gnt = 1'b1;
         // an idle core may still advance while the host uses the memory
         c_en       = ~w_core_req;
      end else begin
         w_core_gnt = w_core_req;
         c_en       = 1'b1;
      end
   end

   assign h_gnt = w_host_gnt;

   // ---------------------------------------------------------------------------
   // Memory mux
   // ---------------------------------------------------------------------------
   always_comb begin
      m_read  = 1'b0;
      m_wren  = 1'b0;
      m_addr  = c_addr;
      m_size  = c_size;
      m_wdata = c_wdata;
      if (rst) begin
         // keep fetching the boot word so the core sees its reset vector
         m_read  = 1'b1;
         m_addr  = BOOT_ADDR;
         m_size  = MEM_WORD;
         m_wdata = '0;
      end else if (w_host_gnt) begin
         m_read  = ~h_wren;
         m_wren  = h_wren;
         m_addr  = h_addr;
         m_size  = h_size;
         m_wdata = h_wdata;
      end else if (w_core_gnt) begin
         m_read  = w_core_is_read;
         m_wren  = c_wren;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state: read-return owner and host burst counter
   // ---------------------------------------------------------------------------
   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (rst) begin
         w_owner_nxt = OWN_CORE;
      end else if (w_host_gnt && !h_wren) begin
         w_owner_nxt = OWN_HOST;
      end else if (w_core_gnt && w_core_is_read) begin
         w_owner_nxt = OWN_CORE;
      end
   end

   always_comb begin
      w_run_nxt = r_run_cnt;
      if (rst) begin
         w_run_nxt = '0;
      end else if (w_host_gnt && w_core_req) begin
         w_run_nxt = RUN_W'(sat_inc(int'(r_run_cnt), HOST_BURST));
      end else if (w_core_gnt || !w_core_req) begin
         // a core grant restores the host's full burst budget
         w_run_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      r_owner   <= w_owner_nxt;
      r_run_cnt <= w_run_nxt;
      if (rst) begin
         r_hold   <= '0;
         r_halted <= 1'b0;
      end else begin
         if (r_owner == OWN_CORE) begin
            r_hold <= m_rdata;
         end
         // parked only once the last core read has returned
         r_halted <= halt_req & (r_owner != OWN_CORE);
      end
   end

   // ---------------------------------------------------------------------------
   // Read return
   // ---------------------------------------------------------------------------
   assign c_rdata  = (r_owner == OWN_CORE) ? m_rdata : r_hold;
   assign h_rdata  = m_rdata;
   // reset drops any return still in flight
   assign h_rvalid = (r_owner == OWN_HOST) & ~rst;
   assign halted   = r_halted & ~rst;

endmodule
